// File: rtl/intc_pkg.sv
// rtl/intc_pkg.sv - shared state encoding, widths and priority helper for interrupt_controller
package intc_pkg;

    localparam int VEC_W   = 14;
    localparam int MAX_SRC = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_SERVICE = 2'b10
    } intc_state_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } prio_t;

    // Lowest set index wins; callers zero-extend narrower vectors to MAX_SRC.
    function automatic prio_t prio_first(input logic [MAX_SRC-1:0] vec);
        prio_t r;
        r.valid = 1'b0;
        r.idx   = '0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r.valid = 1'b1;
                r.idx   = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - per-bit two-flop synchroniser with rising-edge detector
module irq_sync_edge #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [W-1:0] async_i,
    output logic [W-1:0] edge_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;
    logic [W-1:0] hist_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    assign edge_o = sync_q & ~hist_q;

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - prioritised interrupt controller feeding the hazard control unit
// Optional nested preemption is enabled by defining INTC_NESTING_EN.
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int               NUM_SRC    = 8,
    parameter logic [VEC_W-1:0] VEC_BASE   = 14'h0010,
    parameter int               VEC_STRIDE = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    input  logic               int_ack,
    input  logic               int_return,
    output logic               interrupt,
    output logic [VEC_W-1:0]   interrupt_vector_address,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] in_service,
    output logic               busy
);

    intc_state_e        state_q, state_d;
    logic               int_q, int_d;
    logic [VEC_W-1:0]   vec_q, vec_d, vec_calc;
    logic [3:0]         id_q, id_d;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] isv_q, isv_d;
    logic [NUM_SRC-1:0] pend_clr, isv_set, isv_clr;
    logic [NUM_SRC-1:0] edge_w, block, cand, id_onehot, hp_onehot;
    prio_t              win, hp;

    irq_sync_edge #(.W(NUM_SRC)) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .async_i (irq_in),
        .edge_o  (edge_w)
    );

    assign hp        = prio_first(MAX_SRC'(isv_q));
    assign hp_onehot = NUM_SRC'(1) << hp.idx;
    assign id_onehot = NUM_SRC'(1) << id_q;

`ifdef INTC_NESTING_EN
    // Only sources strictly above the highest-priority active handler may preempt.
    logic [MAX_SRC-1:0] ge_mask;
    assign ge_mask = ~((MAX_SRC'(1) << hp.idx) - MAX_SRC'(1));
    assign block   = hp.valid ? ge_mask[NUM_SRC-1:0] : '0;
`else
    assign block   = {NUM_SRC{hp.valid}};
`endif

    assign cand     = pending_q & mask_q & ~block;
    assign win      = prio_first(MAX_SRC'(cand));
    assign vec_calc = VEC_BASE + VEC_W'(win.idx) * VEC_W'(VEC_STRIDE);

    always_comb begin
        state_d  = state_q;
        int_d    = int_q;
        vec_d    = vec_q;
        id_d     = id_q;
        pend_clr = '0;
        isv_set  = '0;
        isv_clr  = '0;
        case (state_q)
            ST_IDLE: begin
                if (win.valid) begin
                    id_d    = win.idx;
                    int_d   = 1'b1;
                    vec_d   = vec_calc;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    pend_clr = id_onehot;
                    isv_set  = id_onehot;
                    int_d    = 1'b0;
                    vec_d    = '0;
                    state_d  = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
`ifdef INTC_NESTING_EN
                if (int_return) begin
                    isv_clr = hp_onehot;
                    if ((isv_q & ~hp_onehot) == '0) begin
                        state_d = ST_IDLE;
                    end
                end else if (win.valid) begin
                    id_d    = win.idx;
                    int_d   = 1'b1;
                    vec_d   = vec_calc;
                    state_d = ST_REQ;
                end
`else
                if (int_return) begin
                    isv_clr = hp_onehot;
                    state_d = ST_IDLE;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A fresh edge in the ack cycle must survive the clear.
    assign pending_d = (pending_q & ~pend_clr) | edge_w;
    assign isv_d     = (isv_q | isv_set) & ~isv_clr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            int_q     <= 1'b0;
            vec_q     <= '0;
            id_q      <= '0;
            mask_q    <= '0;
            pending_q <= '0;
            isv_q     <= '0;
        end else begin
            state_q   <= state_d;
            int_q     <= int_d;
            vec_q     <= vec_d;
            id_q      <= id_d;
            pending_q <= pending_d;
            isv_q     <= isv_d;
            if (mask_we) begin
                mask_q <= mask_wdata;
            end
        end
    end

    assign interrupt                = int_q;
    assign interrupt_vector_address = vec_q;
    assign pending                  = pending_q;
    assign in_service               = isv_q;
    assign busy                     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - directed table-driven bench for interrupt_controller
module tb_interrupt_controller;

    logic        clock;
    logic        reset_n;
    logic [7:0]  irq_in;
    logic        mask_we;
    logic [7:0]  mask_wdata;
    logic        int_ack;
    logic        int_return;
    logic        interrupt;
    logic [13:0] interrupt_vector_address;
    logic [7:0]  pending;
    logic [7:0]  in_service;
    logic        busy;

    int n_vec;
    int n_err;

    typedef struct {
        logic [7:0]  irq;
        logic        mwe;
        logic [7:0]  mwd;
        logic        ack;
        logic        ret;
        logic        e_int;
        logic [13:0] e_vec;
        logic [7:0]  e_pend;
        logic [7:0]  e_isv;
        logic        e_busy;
    } vec_t;

    vec_t tbl[$];

    interrupt_controller dut (
        .clock                    (clock),
        .reset_n                  (reset_n),
        .irq_in                   (irq_in),
        .mask_we                  (mask_we),
        .mask_wdata               (mask_wdata),
        .int_ack                  (int_ack),
        .int_return               (int_return),
        .interrupt                (interrupt),
        .interrupt_vector_address (interrupt_vector_address),
        .pending                  (pending),
        .in_service               (in_service),
        .busy                     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic [7:0] irq, input logic mwe, input logic [7:0] mwd,
                                input logic ack, input logic ret, input logic ei,
                                input logic [13:0] ev, input logic [7:0] ep,
                                input logic [7:0] es, input logic eb);
        vec_t v;
        v.irq = irq; v.mwe = mwe; v.mwd = mwd; v.ack = ack; v.ret = ret;
        v.e_int = ei; v.e_vec = ev; v.e_pend = ep; v.e_isv = es; v.e_busy = eb;
        return v;
    endfunction

    task automatic step(input logic [7:0] irq, input logic mwe, input logic [7:0] mwd,
                        input logic ack, input logic ret);
        @(negedge clock);
        irq_in = irq; mask_we = mwe; mask_wdata = mwd; int_ack = ack; int_return = ret;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic ei, input logic [13:0] ev,
                       input logic [7:0] ep, input logic [7:0] es, input logic eb);
        n_vec++;
        if (interrupt !== ei || interrupt_vector_address !== ev || pending !== ep ||
            in_service !== es || busy !== eb) begin
            n_err++;
            $display("FAIL %s: got int=%b vec=%h pend=%h isv=%h busy=%b, want int=%b vec=%h pend=%h isv=%h busy=%b",
                     name, interrupt, interrupt_vector_address, pending, in_service, busy,
                     ei, ev, ep, es, eb);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset_n = 1'b0; irq_in = '0; mask_we = 1'b0; mask_wdata = '0; int_ack = 1'b0; int_return = 1'b0;

        // mask/irq    mwe  mwd    ack  ret   int vec       pend   isv    busy
        tbl.push_back(mk(8'h00, 1, 8'hFF, 0, 0,  0, 14'h0000, 8'h00, 8'h00, 0));
        tbl.push_back(mk(8'h08, 0, 8'h00, 0, 0,  0, 14'h0000, 8'h00, 8'h00, 0));
        tbl.push_back(mk(8'h08, 0, 8'h00, 0, 0,  0, 14'h0000, 8'h00, 8'h00, 0));
        tbl.push_back(mk(8'h08, 0, 8'h00, 0, 0,  0, 14'h0000, 8'h08, 8'h00, 0));
        tbl.push_back(mk(8'h08, 0, 8'h00, 0, 0,  1, 14'h001C, 8'h08, 8'h00, 1));
        tbl.push_back(mk(8'h08, 0, 8'h00, 1, 0,  0, 14'h0000, 8'h00, 8'h08, 1));
        tbl.push_back(mk(8'h08, 0, 8'h00, 0, 1,  0, 14'h0000, 8'h00, 8'h00, 0));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0,  0, 14'h0000, 8'h00, 8'h00, 0));
        tbl.push_back(mk(8'h22, 0, 8'h00, 0, 0,  0, 14'h0000, 8'h00, 8'h00, 0));
        tbl.push_back(mk(8'h22, 0, 8'h00, 0, 0,  0, 14'h0000, 8'h00, 8'h00, 0));
        tbl.push_back(mk(8'h22, 0, 8'h00, 0, 0,  0, 14'h0000, 8'h22, 8'h00, 0));
        tbl.push_back(mk(8'h22, 0, 8'h00, 0, 0,  1, 14'h0014, 8'h22, 8'h00, 1));
        tbl.push_back(mk(8'h22, 0, 8'h00, 1, 0,  0, 14'h0000, 8'h20, 8'h02, 1));
        tbl.push_back(mk(8'h22, 0, 8'h00, 0, 0,  0, 14'h0000, 8'h20, 8'h02, 1));
        tbl.push_back(mk(8'h22, 0, 8'h00, 0, 1,  0, 14'h0000, 8'h20, 8'h00, 0));
        tbl.push_back(mk(8'h22, 0, 8'h00, 0, 0,  1, 14'h0024, 8'h20, 8'h00, 1));
        tbl.push_back(mk(8'h22, 0, 8'h00, 1, 0,  0, 14'h0000, 8'h00, 8'h20, 1));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 1,  0, 14'h0000, 8'h00, 8'h00, 0));
        tbl.push_back(mk(8'h00, 1, 8'h00, 0, 0,  0, 14'h0000, 8'h00, 8'h00, 0));
        tbl.push_back(mk(8'h04, 0, 8'h00, 0, 0,  0, 14'h0000, 8'h00, 8'h00, 0));
        tbl.push_back(mk(8'h04, 0, 8'h00, 0, 0,  0, 14'h0000, 8'h00, 8'h00, 0));
        tbl.push_back(mk(8'h04, 0, 8'h00, 0, 0,  0, 14'h0000, 8'h04, 8'h00, 0));
        tbl.push_back(mk(8'h04, 0, 8'h00, 0, 0,  0, 14'h0000, 8'h04, 8'h00, 0));
        tbl.push_back(mk(8'h04, 1, 8'h04, 0, 0,  0, 14'h0000, 8'h04, 8'h00, 0));
        tbl.push_back(mk(8'h04, 0, 8'h00, 0, 0,  1, 14'h0018, 8'h04, 8'h00, 1));
        tbl.push_back(mk(8'h04, 0, 8'h00, 1, 0,  0, 14'h0000, 8'h00, 8'h04, 1));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 1,  0, 14'h0000, 8'h00, 8'h00, 0));
        tbl.push_back(mk(8'h00, 1, 8'hFF, 0, 0,  0, 14'h0000, 8'h00, 8'h00, 0));
        tbl.push_back(mk(8'h40, 0, 8'h00, 0, 0,  0, 14'h0000, 8'h00, 8'h00, 0));
        tbl.push_back(mk(8'h40, 0, 8'h00, 0, 0,  0, 14'h0000, 8'h00, 8'h00, 0));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0,  0, 14'h0000, 8'h40, 8'h00, 0));
        tbl.push_back(mk(8'h40, 0, 8'h00, 0, 0,  1, 14'h0028, 8'h40, 8'h00, 1));
        tbl.push_back(mk(8'h40, 0, 8'h00, 0, 0,  1, 14'h0028, 8'h40, 8'h00, 1));
        tbl.push_back(mk(8'h40, 0, 8'h00, 1, 0,  0, 14'h0000, 8'h40, 8'h40, 1));
        tbl.push_back(mk(8'h40, 0, 8'h00, 0, 1,  0, 14'h0000, 8'h40, 8'h00, 0));
        tbl.push_back(mk(8'h40, 0, 8'h00, 0, 0,  1, 14'h0028, 8'h40, 8'h00, 1));
        tbl.push_back(mk(8'h00, 0, 8'h00, 1, 0,  0, 14'h0000, 8'h00, 8'h40, 1));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 1,  0, 14'h0000, 8'h00, 8'h00, 0));
        tbl.push_back(mk(8'h00, 0, 8'h00, 1, 0,  0, 14'h0000, 8'h00, 8'h00, 0));
        tbl.push_back(mk(8'h00, 0, 8'h00, 0, 1,  0, 14'h0000, 8'h00, 8'h00, 0));

        repeat (2) @(posedge clock);
        #1;
        chk("reset", 0, 14'h0000, 8'h00, 8'h00, 0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].irq, tbl[i].mwe, tbl[i].mwd, tbl[i].ack, tbl[i].ret);
            chk($sformatf("row%0d", i), tbl[i].e_int, tbl[i].e_vec, tbl[i].e_pend,
                tbl[i].e_isv, tbl[i].e_busy);
        end

        // Source 4 in service, source 0 arrives.
        repeat (3) step(8'h10, 0, 8'h00, 0, 0);
        chk("t4_pend4", 0, 14'h0000, 8'h10, 8'h00, 0);
        step(8'h10, 0, 8'h00, 0, 0);
        chk("t4_req4", 1, 14'h0020, 8'h10, 8'h00, 1);
        step(8'h10, 0, 8'h00, 1, 0);
        chk("t4_ack4", 0, 14'h0000, 8'h00, 8'h10, 1);
        repeat (3) step(8'h11, 0, 8'h00, 0, 0);
        chk("t4_pend0", 0, 14'h0000, 8'h01, 8'h10, 1);
        step(8'h11, 0, 8'h00, 0, 0);
`ifdef INTC_NESTING_EN
        chk("t4_preempt", 1, 14'h0010, 8'h01, 8'h10, 1);
        step(8'h11, 0, 8'h00, 1, 0);
        chk("t4_ack0", 0, 14'h0000, 8'h00, 8'h11, 1);
        step(8'h11, 0, 8'h00, 0, 1);
        chk("t4_ret0", 0, 14'h0000, 8'h00, 8'h10, 1);
        step(8'h00, 0, 8'h00, 0, 1);
        chk("t4_ret4", 0, 14'h0000, 8'h00, 8'h00, 0);
`else
        chk("t4_noprempt", 0, 14'h0000, 8'h01, 8'h10, 1);
        step(8'h11, 0, 8'h00, 0, 1);
        chk("t4_ret4", 0, 14'h0000, 8'h01, 8'h00, 0);
        step(8'h11, 0, 8'h00, 0, 0);
        chk("t4_req0", 1, 14'h0010, 8'h01, 8'h00, 1);
        step(8'h00, 0, 8'h00, 1, 0);
        chk("t4_ack0", 0, 14'h0000, 8'h00, 8'h01, 1);
        step(8'h00, 0, 8'h00, 0, 1);
        chk("t4_ret0", 0, 14'h0000, 8'h00, 8'h00, 0);
`endif

        // Asynchronous reset while a request is outstanding.
        repeat (3) step(8'h04, 0, 8'h00, 0, 0);
        step(8'h04, 0, 8'h00, 0, 0);
        chk("t5_req", 1, 14'h0018, 8'h04, 8'h00, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_async_rst", 0, 14'h0000, 8'h00, 8'h00, 0);
        @(negedge clock);
        irq_in = '0;
        reset_n = 1'b1;
        step(8'h00, 0, 8'h00, 0, 0);
        chk("t5_idle", 0, 14'h0000, 8'h00, 8'h00, 0);
        repeat (3) step(8'h02, 0, 8'h00, 0, 0);
        chk("t5_pend_masked", 0, 14'h0000, 8'h02, 8'h00, 0);
        step(8'h02, 0, 8'h00, 0, 0);
        chk("t5_mask_cleared", 0, 14'h0000, 8'h02, 8'h00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
